// File: rtl/panda_risc_v_trap_ctrl_pkg.sv
// rtl/panda_risc_v_trap_ctrl_pkg.sv - shared trap sequencer states, interrupt causes and CSR update types
package panda_risc_v_trap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_ENTER     = 2'd2,
        ST_FLUSH     = 2'd3
    } trap_state_t;

    localparam logic [7:0] ITR_CAUSE_SW  = 8'd3;
    localparam logic [7:0] ITR_CAUSE_TMR = 8'd7;
    localparam logic [7:0] ITR_CAUSE_EXT = 8'd11;

    // CSR update types shared with the rest of the execute unit
    localparam logic [1:0] CSR_UPD_WRITE = 2'd0;
    localparam logic [1:0] CSR_UPD_SET   = 2'd1;
    localparam logic [1:0] CSR_UPD_CLR   = 2'd2;

endpackage

// File: rtl/panda_risc_v_itr_arb.sv
// rtl/panda_risc_v_itr_arb.sv - fixed-priority interrupt arbiter (external > software > timer)
module panda_risc_v_itr_arb
    import panda_risc_v_trap_ctrl_pkg::*;
(
    input  logic       mstatus_mie_v,
    input  logic       mie_msie_v,
    input  logic       mie_mtie_v,
    input  logic       mie_meie_v,
    input  logic       sw_itr_req,
    input  logic       tmr_itr_req,
    input  logic       ext_itr_req,
    output logic       itr_pend,
    output logic [7:0] cause
);

    logic ext_p;
    logic sw_p;
    logic tmr_p;

    always_comb begin
        ext_p    = ext_itr_req & mie_meie_v;
        sw_p     = sw_itr_req & mie_msie_v;
        tmr_p    = tmr_itr_req & mie_mtie_v;
        itr_pend = mstatus_mie_v & (ext_p | sw_p | tmr_p);
        if (ext_p)
            cause = ITR_CAUSE_EXT;
        else if (sw_p)
            cause = ITR_CAUSE_SW;
        else if (tmr_p)
            cause = ITR_CAUSE_TMR;
        else
            cause = 8'd0;
    end

endmodule

// File: rtl/panda_risc_v_trap_ctrl.sv
// rtl/panda_risc_v_trap_ctrl.sv - commit-point trap/mret sequencer; PANDA_RISC_V_TRAP_MTVAL_EN builds the mtval register
module panda_risc_v_trap_ctrl
    import panda_risc_v_trap_ctrl_pkg::*;
#(
    parameter real simulation_delay = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmt_valid,
    output logic        cmt_ready,
    output logic        cmt_retire,
    input  logic [31:0] cmt_pc,
    input  logic        cmt_is_expt,
    input  logic [7:0]  cmt_expt_cause,
    input  logic [31:0] cmt_expt_val,
    input  logic        cmt_is_mret,
    input  logic        pipe_idle,
    input  logic        sw_itr_req,
    input  logic        tmr_itr_req,
    input  logic        ext_itr_req,
    input  logic        mstatus_mie_v,
    input  logic        mie_msie_v,
    input  logic        mie_mtie_v,
    input  logic        mie_meie_v,
    output logic        itr_expt_enter,
    output logic        itr_expt_is_intr,
    output logic [7:0]  itr_expt_cause,
    output logic [31:0] itr_expt_ret_addr,
    output logic [31:0] itr_expt_val,
    input  logic [31:0] itr_expt_vec_baseaddr,
    output logic        itr_expt_ret,
    input  logic [31:0] mepc_ret_addr,
    output logic        flush_req,
    output logic [31:0] flush_addr,
    input  logic        flush_ack,
    output logic        trap_busy
);

    // The delay only matters to behavioural models; nothing is built from it.
    if (simulation_delay < 0.0) begin : g_sim_delay_check
    end

    trap_state_t state;
    trap_state_t state_nxt;
    logic        itr_pend;
    logic [7:0]  itr_cause;
    logic        hs;
    logic        take_itr;
    logic        take_expt;
    logic        take_ret;
    logic        is_ret;

    panda_risc_v_itr_arb u_itr_arb (
        .mstatus_mie_v (mstatus_mie_v),
        .mie_msie_v    (mie_msie_v),
        .mie_mtie_v    (mie_mtie_v),
        .mie_meie_v    (mie_meie_v),
        .sw_itr_req    (sw_itr_req),
        .tmr_itr_req   (tmr_itr_req),
        .ext_itr_req   (ext_itr_req),
        .itr_pend      (itr_pend),
        .cause         (itr_cause)
    );

    // Interrupt beats exception beats mret; an interrupted mret re-executes later.
    assign hs        = cmt_valid & (state == ST_IDLE);
    assign take_itr  = hs & itr_pend;
    assign take_expt = hs & ~itr_pend & cmt_is_expt;
    assign take_ret  = hs & ~itr_pend & ~cmt_is_expt & cmt_is_mret;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (take_itr | take_expt | take_ret) state_nxt = ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (pipe_idle) state_nxt = ST_ENTER;
            ST_ENTER:     state_nxt = ST_FLUSH;
            ST_FLUSH:     if (flush_ack) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmt_ready      = (state == ST_IDLE);
        trap_busy      = (state != ST_IDLE);
        cmt_retire     = hs & ~itr_pend & ~cmt_is_expt;
        itr_expt_enter = (state == ST_ENTER) & ~is_ret;
        itr_expt_ret   = (state == ST_ENTER) & is_ret;
        flush_req      = (state == ST_FLUSH);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            itr_expt_is_intr  <= 1'b0;
            itr_expt_cause    <= 8'd0;
            itr_expt_ret_addr <= 32'd0;
            is_ret            <= 1'b0;
            flush_addr        <= 32'd0;
        end else begin
            if (take_itr | take_expt) begin
                itr_expt_is_intr  <= take_itr;
                itr_expt_cause    <= take_itr ? itr_cause : cmt_expt_cause;
                itr_expt_ret_addr <= cmt_pc;
                is_ret            <= 1'b0;
            end else if (take_ret) begin
                is_ret <= 1'b1;
            end
            if (state == ST_ENTER)
                flush_addr <= is_ret ? mepc_ret_addr : itr_expt_vec_baseaddr;
        end
    end

`ifdef PANDA_RISC_V_TRAP_MTVAL_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            itr_expt_val <= 32'd0;
        else if (take_itr)
            itr_expt_val <= 32'd0;
        else if (take_expt)
            itr_expt_val <= cmt_expt_val;
    end
`else
    logic unused_expt_val;
    assign unused_expt_val = ^cmt_expt_val;
    assign itr_expt_val    = 32'd0;
`endif

endmodule

// File: tb/tb_panda_risc_v_trap_ctrl.sv
// tb/tb_panda_risc_v_trap_ctrl.sv - randomized self-checking bench for panda_risc_v_trap_ctrl
module tb_panda_risc_v_trap_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmt_valid = 1'b0;
    logic        cmt_ready;
    logic        cmt_retire;
    logic [31:0] cmt_pc = '0;
    logic        cmt_is_expt = 1'b0;
    logic [7:0]  cmt_expt_cause = '0;
    logic [31:0] cmt_expt_val = '0;
    logic        cmt_is_mret = 1'b0;
    logic        pipe_idle = 1'b1;
    logic        sw_itr_req = 1'b0;
    logic        tmr_itr_req = 1'b0;
    logic        ext_itr_req = 1'b0;
    logic        mstatus_mie_v = 1'b0;
    logic        mie_msie_v = 1'b0;
    logic        mie_mtie_v = 1'b0;
    logic        mie_meie_v = 1'b0;
    logic        itr_expt_enter;
    logic        itr_expt_is_intr;
    logic [7:0]  itr_expt_cause;
    logic [31:0] itr_expt_ret_addr;
    logic [31:0] itr_expt_val;
    logic [31:0] itr_expt_vec_baseaddr = '0;
    logic        itr_expt_ret;
    logic [31:0] mepc_ret_addr = '0;
    logic        flush_req;
    logic [31:0] flush_addr;
    logic        flush_ack = 1'b0;
    logic        trap_busy;

    int n_tests = 0;
    int n_fail = 0;

    // staged stimulus for one commit
    logic [31:0] s_pc, s_val, s_vec, s_mepc;
    logic [7:0]  s_cause;
    logic        s_expt, s_mret, s_sw, s_tmr, s_ext, s_mie, s_msie, s_mtie, s_meie;

    // reference view of the trap information registers
    logic        m_is_intr = 1'b0;
    logic [7:0]  m_cause = '0;
    logic [31:0] m_ret_addr = '0;
    logic [31:0] m_val = '0;

    panda_risc_v_trap_ctrl dut (
        .clk                   (clk),
        .resetn                (resetn),
        .cmt_valid             (cmt_valid),
        .cmt_ready             (cmt_ready),
        .cmt_retire            (cmt_retire),
        .cmt_pc                (cmt_pc),
        .cmt_is_expt           (cmt_is_expt),
        .cmt_expt_cause        (cmt_expt_cause),
        .cmt_expt_val          (cmt_expt_val),
        .cmt_is_mret           (cmt_is_mret),
        .pipe_idle             (pipe_idle),
        .sw_itr_req            (sw_itr_req),
        .tmr_itr_req           (tmr_itr_req),
        .ext_itr_req           (ext_itr_req),
        .mstatus_mie_v         (mstatus_mie_v),
        .mie_msie_v            (mie_msie_v),
        .mie_mtie_v            (mie_mtie_v),
        .mie_meie_v            (mie_meie_v),
        .itr_expt_enter        (itr_expt_enter),
        .itr_expt_is_intr      (itr_expt_is_intr),
        .itr_expt_cause        (itr_expt_cause),
        .itr_expt_ret_addr     (itr_expt_ret_addr),
        .itr_expt_val          (itr_expt_val),
        .itr_expt_vec_baseaddr (itr_expt_vec_baseaddr),
        .itr_expt_ret          (itr_expt_ret),
        .mepc_ret_addr         (mepc_ret_addr),
        .flush_req             (flush_req),
        .flush_addr            (flush_addr),
        .flush_ack             (flush_ack),
        .trap_busy             (trap_busy)
    );

    always #5 clk = ~clk;

    task automatic clear_stim();
        s_pc = '0; s_val = '0; s_vec = '0; s_mepc = '0; s_cause = '0;
        s_expt = 0; s_mret = 0; s_sw = 0; s_tmr = 0; s_ext = 0;
        s_mie = 0; s_msie = 0; s_mtie = 0; s_meie = 0;
    endtask

    // One commit through the whole trap sequence; kind: 0 plain, 1 interrupt, 2 exception, 3 mret.
    task automatic run_trans(input int idle_wait, input int ack_wait, input bit rst_in_flush);
        bit p_ext, p_sw, p_tmr, itr;
        int kind;
        logic [7:0]  e_cause;
        logic [31:0] e_faddr, held_faddr;
        p_ext = s_mie & s_ext & s_meie;
        p_sw  = s_mie & s_sw & s_msie;
        p_tmr = s_mie & s_tmr & s_mtie;
        itr   = p_ext | p_sw | p_tmr;
        e_cause = p_ext ? 8'd11 : (p_sw ? 8'd3 : 8'd7);
        kind = itr ? 1 : (s_expt ? 2 : (s_mret ? 3 : 0));
        if (kind == 1) begin
            m_is_intr = 1; m_cause = e_cause; m_ret_addr = s_pc; m_val = 0;
        end else if (kind == 2) begin
            m_is_intr = 0; m_cause = s_cause; m_ret_addr = s_pc;
`ifdef PANDA_RISC_V_TRAP_MTVAL_EN
            m_val = s_val;
`else
            m_val = 0;
`endif
        end
        e_faddr = (kind == 3) ? s_mepc : s_vec;

        @(negedge clk);
        cmt_valid = 1; cmt_pc = s_pc; cmt_is_expt = s_expt; cmt_expt_cause = s_cause;
        cmt_expt_val = s_val; cmt_is_mret = s_mret; sw_itr_req = s_sw; tmr_itr_req = s_tmr;
        ext_itr_req = s_ext; mstatus_mie_v = s_mie; mie_msie_v = s_msie; mie_mtie_v = s_mtie;
        mie_meie_v = s_meie; itr_expt_vec_baseaddr = s_vec; mepc_ret_addr = s_mepc;
        pipe_idle = (idle_wait == 0);
        #1;
        n_tests++;
        if (cmt_ready !== 1'b1 || cmt_retire !== (kind == 0 || kind == 3)) begin
            n_fail++;
            $display("FAIL handshake: ready=%b retire=%b, required ready=1 retire=%b", cmt_ready, cmt_retire, (kind == 0 || kind == 3));
        end

        @(negedge clk);
        cmt_valid = 0;
        sw_itr_req = 1'($urandom); tmr_itr_req = 1'($urandom); ext_itr_req = 1'($urandom);
        #1;
        n_tests++;
        if (trap_busy !== (kind != 0) || cmt_ready !== (kind == 0)) begin
            n_fail++;
            $display("FAIL event_state: busy=%b ready=%b, required busy=%b", trap_busy, cmt_ready, (kind != 0));
        end
        n_tests++;
        if (itr_expt_is_intr !== m_is_intr || itr_expt_cause !== m_cause ||
            itr_expt_ret_addr !== m_ret_addr || itr_expt_val !== m_val) begin
            n_fail++;
            $display("FAIL latch: intr=%b cause=%0d ret=%h val=%h, required %b %0d %h %h",
                     itr_expt_is_intr, itr_expt_cause, itr_expt_ret_addr, itr_expt_val,
                     m_is_intr, m_cause, m_ret_addr, m_val);
        end
        if (kind == 0) return;

        for (int i = 0; i < idle_wait; i++) begin
            flush_ack = 1'($urandom);
            #1;
            n_tests++;
            if (itr_expt_enter !== 1'b0 || itr_expt_ret !== 1'b0 || cmt_ready !== 1'b0 || flush_req !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_stall: enter=%b ret=%b ready=%b flush=%b, required 0 0 0 0",
                         itr_expt_enter, itr_expt_ret, cmt_ready, flush_req);
            end
            @(negedge clk);
        end
        flush_ack = 0;
        pipe_idle = 1;
        @(negedge clk);
        #1;
        n_tests++;
        if (itr_expt_enter !== (kind != 3) || itr_expt_ret !== (kind == 3) || flush_req !== 1'b0 ||
            itr_expt_cause !== m_cause || itr_expt_ret_addr !== m_ret_addr) begin
            n_fail++;
            $display("FAIL enter_pulse: enter=%b ret=%b flush=%b cause=%0d, required %b %b 0 %0d",
                     itr_expt_enter, itr_expt_ret, flush_req, itr_expt_cause, (kind != 3), (kind == 3), m_cause);
        end

        @(negedge clk);
        itr_expt_vec_baseaddr = $urandom; mepc_ret_addr = $urandom;
        #1;
        n_tests++;
        if (flush_req !== 1'b1 || flush_addr !== e_faddr || itr_expt_enter !== 1'b0 || itr_expt_ret !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: req=%b addr=%h enter=%b ret=%b, required 1 %h 0 0",
                     flush_req, flush_addr, itr_expt_enter, itr_expt_ret, e_faddr);
        end
        held_faddr = e_faddr;
        for (int j = 0; j < ack_wait; j++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (flush_req !== 1'b1 || flush_addr !== held_faddr || cmt_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_hold: req=%b addr=%h ready=%b, required 1 %h 0", flush_req, flush_addr, cmt_ready, held_faddr);
            end
        end

        if (rst_in_flush) begin
            #2 resetn = 0;
            #1;
            n_tests++;
            if (flush_req !== 1'b0 || cmt_ready !== 1'b1 || trap_busy !== 1'b0 || flush_addr !== 32'd0 ||
                itr_expt_cause !== 8'd0 || itr_expt_ret_addr !== 32'd0 || itr_expt_val !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_in_flush: req=%b ready=%b busy=%b faddr=%h cause=%0d, required 0 1 0 0 0",
                         flush_req, cmt_ready, trap_busy, flush_addr, itr_expt_cause);
            end
            m_is_intr = 0; m_cause = 0; m_ret_addr = 0; m_val = 0;
            @(negedge clk);
            resetn = 1;
            return;
        end

        flush_ack = 1;
        @(negedge clk);
        flush_ack = 0;
        #1;
        n_tests++;
        if (cmt_ready !== 1'b1 || trap_busy !== 1'b0 || flush_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_return: ready=%b busy=%b flush=%b, required 1 0 0", cmt_ready, trap_busy, flush_req);
        end
    endtask

    task automatic test_reset();
        resetn = 0;
        #13;
        n_tests++;
        if (cmt_ready !== 1'b1 || trap_busy !== 1'b0 || itr_expt_enter !== 1'b0 || itr_expt_ret !== 1'b0 ||
            flush_req !== 1'b0 || cmt_retire !== 1'b0 || itr_expt_cause !== 8'd0 ||
            itr_expt_ret_addr !== 32'd0 || itr_expt_val !== 32'd0 || flush_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: ready=%b busy=%b enter=%b flush=%b cause=%0d faddr=%h, required 1 0 0 0 0 0",
                     cmt_ready, trap_busy, itr_expt_enter, flush_req, itr_expt_cause, flush_addr);
        end
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_exception();
        clear_stim();
        s_expt = 1; s_cause = 8'd2; s_pc = 32'h100; s_val = 32'hDEAD; s_vec = 32'h80;
        run_trans(0, 0, 0);
    endtask

    task automatic test_interrupt_priority();
        clear_stim();
        s_mie = 1; s_msie = 1; s_mtie = 1; s_meie = 1; s_ext = 1; s_tmr = 1; s_pc = 32'h200; s_vec = 32'h84;
        run_trans(0, 1, 0);
        clear_stim();
        s_mie = 1; s_msie = 1; s_mtie = 1; s_meie = 1; s_sw = 1; s_tmr = 1; s_pc = 32'h204; s_vec = 32'h88;
        s_expt = 1; s_cause = 8'd5; s_val = 32'h1234;
        run_trans(0, 0, 0);
    endtask

    task automatic test_mret();
        clear_stim();
        s_mret = 1; s_mepc = 32'h300; s_pc = 32'h120; s_vec = 32'h80;
        run_trans(0, 0, 0);
        clear_stim();
        s_mret = 1; s_mie = 1; s_mtie = 1; s_tmr = 1; s_pc = 32'h124; s_mepc = 32'h300; s_vec = 32'h90;
        run_trans(0, 0, 0);
        clear_stim();
        s_mret = 1; s_expt = 1; s_cause = 8'd4; s_pc = 32'h128; s_val = 32'h55; s_mepc = 32'h300; s_vec = 32'h94;
        run_trans(1, 0, 0);
    endtask

    task automatic test_drain_stall();
        clear_stim();
        s_expt = 1; s_cause = 8'd6; s_pc = 32'h400; s_val = 32'hBEEF; s_vec = 32'hA0;
        run_trans(5, 0, 0);
    endtask

    task automatic test_flush_hold_reset();
        clear_stim();
        s_expt = 1; s_cause = 8'd1; s_pc = 32'h500; s_val = 32'h77; s_vec = 32'hC0;
        run_trans(0, 3, 0);
        clear_stim();
        s_mie = 1; s_meie = 1; s_ext = 1; s_pc = 32'h504; s_vec = 32'hC4;
        run_trans(2, 1, 1);
    endtask

    task automatic test_masking();
        clear_stim();
        s_ext = 1; s_meie = 1; s_msie = 1; s_mtie = 1; s_sw = 1; s_tmr = 1; s_pc = 32'h600;
        run_trans(0, 0, 0);
        clear_stim();
        s_mie = 1; s_ext = 1; s_tmr = 1; s_mtie = 0; s_meie = 0; s_pc = 32'h604;
        run_trans(0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            s_pc = $urandom & 32'hFFFF_FFFC; s_val = $urandom; s_vec = $urandom; s_mepc = $urandom;
            s_cause = 8'($urandom_range(0, 15));
            s_expt = ($urandom_range(0, 3) == 0); s_mret = ($urandom_range(0, 3) == 0);
            s_sw = 1'($urandom); s_tmr = 1'($urandom); s_ext = 1'($urandom);
            s_mie = ($urandom_range(0, 2) == 0); s_msie = 1'($urandom); s_mtie = 1'($urandom);
            s_meie = 1'($urandom);
            run_trans($urandom_range(0, 3), $urandom_range(0, 2), 0);
        end
    endtask

    initial begin
        test_reset();
        test_exception();
        test_interrupt_priority();
        test_mret();
        test_drain_stall();
        test_flush_hold_reset();
        test_masking();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
